// File: rtl/dtree_channel_arbiter_if.sv
// Bundle of the channel-side, core-side and result signals of the dtree
// channel arbiter. The master modport is the arbiter itself; the slave
// modport is the surrounding front ends, dtree core and result sink.
interface dtree_channel_arbiter_if #(
  parameter int CHANNELS = 4,
  parameter int FEATURES = 3,
  parameter int IN_WIDTH = 10
);
  localparam int CHW = $clog2(CHANNELS);
  localparam int LW  = $clog2(FEATURES);

  // per-electrode streams
  logic [CHANNELS-1:0]          ch_valid;
  logic [CHANNELS-1:0]          ch_ready;
  logic [CHANNELS*IN_WIDTH-1:0] ch_sample;

  // shared dtree core
  logic                         core_in_valid;
  logic                         core_ready;
  logic [IN_WIDTH-1:0]          core_sample;
  logic [LW-1:0]                core_level;
  logic [LW-1:0]                core_path;
  logic                         core_out_valid;

  // tagged classification result
  logic                         res_valid;
  logic [CHW-1:0]               res_channel;
  logic [LW-1:0]                res_level;
  logic [LW-1:0]                res_path;
  logic                         res_timeout;

  modport master (
    input  ch_valid, ch_sample, core_ready, core_level, core_path, core_out_valid,
    output ch_ready, core_in_valid, core_sample,
    output res_valid, res_channel, res_level, res_path, res_timeout
  );

  modport slave (
    output ch_valid, ch_sample, core_ready, core_level, core_path, core_out_valid,
    input  ch_ready, core_in_valid, core_sample,
    input  res_valid, res_channel, res_level, res_path, res_timeout
  );
endinterface

// File: rtl/dtree_channel_arbiter.sv
// Round-robin scheduler sharing one dtree classification core between
// CHANNELS sample streams: grant a channel, forward FEATURES samples,
// wait (bounded) for the classification, report it tagged with the channel.
module dtree_channel_arbiter #(
  parameter int CHANNELS = 4,
  parameter int FEATURES = 3,
  parameter int IN_WIDTH = 10,
  parameter int TIMEOUT  = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  dtree_channel_arbiter_if.master bus
);
  localparam int unsigned NCH = CHANNELS;
  localparam int CHW = $clog2(CHANNELS);
  localparam int FCW = $clog2(FEATURES);
  localparam int WCW = $clog2(TIMEOUT + 1);

  localparam logic [CHW-1:0] LAST_CH   = CHW'(CHANNELS - 1);
  localparam logic [FCW-1:0] LAST_FEAT = FCW'(FEATURES - 1);
  localparam logic [WCW-1:0] LAST_WAIT = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT,
    REPORT
  } state_t;

  state_t         state;
  logic [CHW-1:0] rr_ptr;
  logic [CHW-1:0] grant;
  logic [FCW-1:0] frame_cnt;
  logic [WCW-1:0] wait_cnt;

  logic [IN_WIDTH-1:0] samples [CHANNELS];
  logic                found;
  logic [CHW-1:0]      pick;
  logic [CHW-1:0]      cand;
  int unsigned         idx;
  logic                xfer;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign samples[g] = bus.ch_sample[g*IN_WIDTH +: IN_WIDTH];
  end

  // first requesting channel at or after rr_ptr, wrapping modulo CHANNELS
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      cand = CHW'(idx);
      if (!found && bus.ch_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // combinational pass-through of the granted channel into the core
  always_comb begin
    bus.ch_ready      = '0;
    bus.core_in_valid = 1'b0;
    bus.core_sample   = '0;
    if (state == STREAM) begin
      bus.ch_ready[grant] = bus.core_ready;
      bus.core_in_valid   = bus.ch_valid[grant];
      bus.core_sample     = samples[grant];
    end
  end

  assign xfer = (state == STREAM) && bus.ch_valid[grant] && bus.core_ready;

  // scheduler FSM; the res_* registers double as the result capture
  // registers, loaded on WAIT exit so they are stable during REPORT and after
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant           <= '0;
      frame_cnt       <= '0;
      wait_cnt        <= '0;
      bus.res_valid   <= 1'b0;
      bus.res_timeout <= 1'b0;
      bus.res_channel <= '0;
      bus.res_level   <= '0;
      bus.res_path    <= '0;
    end else begin
      bus.res_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (frame_cnt == LAST_FEAT) begin
              frame_cnt <= '0;
              wait_cnt  <= '0;
              state     <= WAIT;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        WAIT: begin
          if (bus.core_out_valid) begin
            bus.res_level   <= bus.core_level;
            bus.res_path    <= bus.core_path;
            bus.res_timeout <= 1'b0;
            bus.res_channel <= grant;
            bus.res_valid   <= 1'b1;
            state           <= REPORT;
          end else if (wait_cnt == LAST_WAIT) begin
            bus.res_level   <= '0;
            bus.res_path    <= '0;
            bus.res_timeout <= 1'b1;
            bus.res_channel <= grant;
            bus.res_valid   <= 1'b1;
            state           <= REPORT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        REPORT: begin
          rr_ptr <= (grant == LAST_CH) ? '0 : grant + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dtree_channel_arbiter.sv
// Directed bench for dtree_channel_arbiter: the bench plays front ends and
// dtree core; expected samples and results are queued when a frame is
// launched and checked as the arbiter forwards/reports them.
module tb_dtree_channel_arbiter;
  localparam int CH  = 4;
  localparam int FT  = 3;
  localparam int IW  = 10;
  localparam int TMO = 4;

  logic clk;
  logic reset;

  dtree_channel_arbiter_if #(.CHANNELS(CH), .FEATURES(FT), .IN_WIDTH(IW)) bus ();

  dtree_channel_arbiter #(
    .CHANNELS(CH),
    .FEATURES(FT),
    .IN_WIDTH(IW),
    .TIMEOUT (TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int xfer_cnt = 0;
  int exp_ch = 0;
  bit bp_mode = 0;
  logic [IW-1:0] exp_smp [$];
  logic [6:0]    exp_res [$];
  logic [3:0]    mon_oh;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_ch_ready"},      32'(bus.ch_ready), 0);
    check({tag, "_core_in_valid"}, 32'(bus.core_in_valid), 0);
    check({tag, "_core_sample"},   32'(bus.core_sample), 0);
    check({tag, "_res_valid"},     32'(bus.res_valid), 0);
    check({tag, "_res_timeout"},   32'(bus.res_timeout), 0);
    check({tag, "_res_channel"},   32'(bus.res_channel), 0);
    check({tag, "_res_level"},     32'(bus.res_level), 0);
    check({tag, "_res_path"},      32'(bus.res_path), 0);
  endtask

  // scoreboard side: grant exclusivity, forwarded samples, results
  always @(negedge clk) begin
    mon_oh = 4'b0001 << exp_ch;
    if (bus.core_in_valid || bus.ch_ready != 4'b0)
      check("ch_ready_grant", 32'(bus.ch_ready), 32'(bus.core_ready ? mon_oh : 4'b0));
    if (bus.core_in_valid && bus.core_ready) begin
      xfer_cnt++;
      if (exp_smp.size() == 0) check("sample_pending", exp_smp.size(), 1);
      else check("core_sample", 32'(bus.core_sample), 32'(exp_smp.pop_front()));
    end
    if (bus.res_valid) begin
      if (exp_res.size() == 0) check("res_pending", exp_res.size(), 1);
      else check("result_ch_lvl_path_to",
                 32'({bus.res_channel, bus.res_level, bus.res_path, bus.res_timeout}),
                 32'(exp_res.pop_front()));
    end
  end

  // offer nx samples on channel ch; returns in the cycle after the last transfer
  task automatic run_frame(int ch, logic [IW-1:0] s0, logic [IW-1:0] s1,
                           logic [IW-1:0] s2, int nx, bit keep);
    logic [IW-1:0] smp [3];
    int base;
    int n;
    smp = '{s0, s1, s2};
    @(posedge clk); #1;
    exp_ch = ch;
    for (int i = 0; i < nx; i++) exp_smp.push_back(smp[i]);
    base = xfer_cnt;
    bus.ch_valid[ch] = 1'b1;
    bus.ch_sample[ch*IW +: IW] = smp[0];
    n = 0;
    while ((xfer_cnt - base) < nx && n < 40) begin
      @(posedge clk); #1;
      if ((xfer_cnt - base) < FT) bus.ch_sample[ch*IW +: IW] = smp[xfer_cnt - base];
      if (bp_mode) bus.core_ready = ~bus.core_ready;
      n++;
    end
    check("frame_xfers", xfer_cnt - base, nx);
    if (!keep) bus.ch_valid[ch] = 1'b0;
  endtask

  // core answers in cycle L+delay (L = last transfer); result due at L+delay+1
  task automatic respond(int ch, int delay, int lvl, int path);
    exp_res.push_back({2'(ch), 2'(lvl), 2'(path), 1'b0});
    repeat (delay - 1) begin @(posedge clk); #1; end
    bus.core_out_valid = 1'b1;
    bus.core_level     = 2'(lvl);
    bus.core_path      = 2'(path);
    @(posedge clk); #1;
    bus.core_out_valid = 1'b0;
    bus.core_level     = 2'd3;
    bus.core_path      = 2'd3;
    @(negedge clk);
    check("res_latency", 32'(bus.res_valid), 1);
  endtask

  // no core answer: timeout result due TIMEOUT+1 cycles after the last transfer
  task automatic expect_timeout(int ch);
    exp_res.push_back({2'(ch), 2'd0, 2'd0, 1'b1});
    for (int i = 1; i <= TMO + 1; i++) begin
      @(negedge clk);
      check("timeout_latency", 32'(bus.res_valid), (i == TMO + 1) ? 1 : 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.ch_valid = '0;
    bus.ch_sample = '0;
    bus.core_ready = 1'b1;
    bus.core_out_valid = 1'b0;
    bus.core_level = 2'd3;
    bus.core_path = 2'd3;
    #1;
    check_zero("reset0");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset1");
    reset = 1'b1;

    // round robin: all continuously valid, results 0,1,2,3,0
    bus.ch_valid = '1;
    for (int f = 0; f < 5; f++) begin
      run_frame(f % 4, 10'(100 + f*8), 10'(101 + f*8), 10'(102 + f*8), FT, 1'b1);
      if (f == 4) bus.ch_valid = '0;
      respond(f % 4, 1, f % 3, (f + 1) % 3);
    end

    // single channel 2: samples 5,6,7, core answers two cycles later
    run_frame(2, 10'd5, 10'd6, 10'd7, FT, 1'b0);
    respond(2, 2, 1, 2);

    // backpressure: core_ready toggles during the frame
    bp_mode = 1'b1;
    run_frame(3, 10'd11, 10'd12, 10'd13, FT, 1'b0);
    bp_mode = 1'b0;
    bus.core_ready = 1'b1;
    respond(3, 1, 0, 1);

    // timeout on ch 0 while ch 1 waits; next grant must be ch 1
    bus.ch_valid[1] = 1'b1;
    run_frame(0, 10'd21, 10'd22, 10'd23, FT, 1'b0);
    expect_timeout(0);
    run_frame(1, 10'd31, 10'd32, 10'd33, FT, 1'b0);
    respond(1, 1, 2, 2);

    // result arrives on the last WAIT cycle: classification wins
    run_frame(2, 10'd41, 10'd42, 10'd43, FT, 1'b0);
    respond(2, TMO, 2, 1);

    // reset after two transfers on ch 1
    run_frame(1, 10'd51, 10'd52, 10'd53, 2, 1'b1);
    reset = 1'b0;
    #1;
    check_zero("rst_mid");
    bus.ch_valid[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_res_valid", 32'(bus.res_valid), 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    run_frame(1, 10'd61, 10'd62, 10'd63, FT, 1'b0);
    respond(1, 1, 1, 1);
    run_frame(3, 10'd71, 10'd72, 10'd73, FT, 1'b0);
    respond(3, 1, 2, 0);

    repeat (3) @(posedge clk);
    #1;
    check("smp_queue_empty", exp_smp.size(), 0);
    check("res_queue_empty", exp_res.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
